// File: rtl/alu_sequencer.sv
// Request/response sequencer for the 8-bit, 8-op combinational ALU.
// Latches one operation per handshake and iterates single-bit LSL/LSR into multi-bit shifts.
module alu_sequencer #(
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_func_i,
    input  logic [7:0]         req_a_i,
    input  logic [7:0]         req_b_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [7:0]         rsp_result_o,
    output logic               rsp_fz_o,
    output logic               rsp_fc_o,
    output logic [1:0]         flags_o,
    output logic               busy_o,
    output logic [7:0]         alu_a_imm_o,
    output logic [7:0]         alu_a_mem_o,
    output logic [7:0]         alu_b_o,
    output logic [2:0]         alu_func_o,
    input  logic [7:0]         alu_result_i,
    input  logic               alu_fz_i,
    input  logic               alu_fc_i
);

    localparam int unsigned DW = 8;
    localparam int unsigned FW = 3;
    localparam logic [FW-1:0] FN_LSL = 3'b110;
    localparam logic [FW-1:0] FN_LSR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      opr_q, opr_d;
    logic [DW-1:0]      b_q, b_d;
    logic [FW-1:0]      func_q, func_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]      res_q, res_d;
    logic               fz_q, fz_d;
    logic               fc_q, fc_d;
    logic [1:0]         flags_q, flags_d;
    logic               is_shift;

    assign is_shift = (func_q == FN_LSL) || (func_q == FN_LSR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            opr_q   <= '0;
            b_q     <= '0;
            func_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            b_q     <= b_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
            flags_q <= flags_d;
        end
    end

    // Next-state: one ALU pass per cycle, shift results fed back through opr until the count reaches 1.
    always_comb begin
        state_d = state_q;
        opr_d   = opr_q;
        b_d     = b_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        flags_d = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    opr_d   = req_a_i;
                    b_d     = req_b_i;
                    func_d  = req_func_i;
                    cnt_d   = req_b_i[SHAMT_W-1:0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_shift && (cnt_q == '0)) begin
                    res_d   = opr_q;
                    fz_d    = (opr_q == '0);
                    fc_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (is_shift && (cnt_q > SHAMT_W'(1))) begin
                    opr_d   = alu_result_i;
                    cnt_d   = cnt_q - SHAMT_W'(1);
                    state_d = ST_SHIFT;
                end else begin
                    res_d   = alu_result_i;
                    fz_d    = alu_fz_i;
                    fc_d    = alu_fc_i;
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q > SHAMT_W'(1)) begin
                    opr_d = alu_result_i;
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    res_d   = alu_result_i;
                    fz_d    = alu_fz_i;
                    fc_d    = alu_fc_i;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    flags_d = {fc_q, fz_q};
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_DONE);
    assign rsp_result_o = res_q;
    assign rsp_fz_o     = fz_q;
    assign rsp_fc_o     = fc_q;
    assign flags_o      = flags_q;

    assign alu_a_imm_o  = opr_q;
    assign alu_a_mem_o  = opr_q;
    assign alu_b_o      = b_q;
    assign alu_func_o   = func_q;

endmodule
